// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding word fetch and a one-entry skid
// buffer feeding decode. Redirects flush buffered words and drop an in-flight fetch.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stallD,
   output logic        validD,
   output logic [31:0] instrD,
   output logic [31:0] pcD
);

   localparam logic [1:0]  StReq  = 2'd0;
   localparam logic [1:0]  StWait = 2'd1;
   localparam logic [1:0]  StDrop = 2'd2;
   localparam logic [31:0] Nop    = 32'h0000_0013;

   logic [1:0]  state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic        skid_v_q, skid_v_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc_q, skid_pc_d;

   logic accept;
   logic rsp_wait;
   logic consume;

   // A full skid buffer holds off new requests so it never competes with a response.
   assign imem_req  = ~reset & (state_q == StReq) & ~skid_v_q;
   assign imem_addr = fetch_pc_q;
   assign accept    = imem_req & imem_ready;
   assign rsp_wait  = (state_q == StWait) & imem_rvalid;
   assign consume   = valid_q & ~stallD;

   assign validD = valid_q;
   assign instrD = instr_q;
   assign pcD    = pc_q;

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      req_pc_d     = req_pc_q;
      valid_d      = valid_q;
      instr_d      = instr_q;
      pc_d         = pc_q;
      skid_v_d     = skid_v_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;

      case (state_q)
         StReq: begin
            if (accept) begin
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = StWait;
            end
         end
         StWait:  if (imem_rvalid) state_d = StReq;
         StDrop:  if (imem_rvalid) state_d = StReq;
         default: state_d = StReq;
      endcase

      if (consume) begin
         if (skid_v_q) begin
            valid_d  = 1'b1;
            instr_d  = skid_instr_q;
            pc_d     = skid_pc_q;
            skid_v_d = 1'b0;
         end else begin
            valid_d = 1'b0;
         end
      end

      if (rsp_wait) begin
         if (~valid_q | ~stallD) begin
            valid_d = 1'b1;
            instr_d = imem_rdata;
            pc_d    = req_pc_q;
         end else begin
            skid_v_d     = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = req_pc_q;
         end
      end

      if (redirect) begin
         valid_d    = 1'b0;
         skid_v_d   = 1'b0;
         fetch_pc_d = redirect_pc & ~32'd3;
         // Any fetch still owed by memory must be swallowed before refetching.
         if (((state_q == StWait) && !imem_rvalid) || ((state_q == StReq) && accept) ||
             ((state_q == StDrop) && !imem_rvalid)) begin
            state_d = StDrop;
         end else begin
            state_d = StReq;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StReq;
         fetch_pc_q   <= RESET_PC;
         req_pc_q     <= RESET_PC;
         valid_q      <= 1'b0;
         instr_q      <= Nop;
         pc_q         <= 32'h0;
         skid_v_q     <= 1'b0;
         skid_instr_q <= Nop;
         skid_pc_q    <= 32'h0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         req_pc_q     <= req_pc_d;
         valid_q      <= valid_d;
         instr_q      <= instr_d;
         pc_q         <= pc_d;
         skid_v_q     <= skid_v_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-programmable memory model, scoreboard of expected decode
// outputs popped by a monitor, plus directed cycle checks and a wrap-around instance.
module tb_fetch_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        imem_ready = 1'b1;
   logic        mem_rvalid;
   logic        stray_rv = 1'b0;
   logic        dut_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        stallD = 1'b0;
   logic        imem_req, validD;
   logic [31:0] imem_addr, instrD, pcD;

   int checks = 0;
   int errors = 0;
   int lat = 1;
   logic [63:0] exp_q[$];
   logic [63:0] e;

   assign dut_rvalid = mem_rvalid | stray_rv;

   fetch_stage u_dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rvalid(dut_rvalid),
      .imem_rdata (imem_rdata),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .stallD     (stallD),
      .validD     (validD),
      .instrD     (instrD),
      .pcD        (pcD)
   );

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (a == 32'h0000_1000) return 32'h00A0_0093;
      if (a == 32'h0000_1004) return 32'h0010_8113;
      return {a[15:0], 16'h0013};
   endfunction

   // Memory: one outstanding request, response visible 'lat' cycles after acceptance.
   logic        pend_v;
   int          pend_cnt;
   logic [31:0] pend_addr;
   always @(posedge clk) begin
      if (reset) begin
         pend_v     <= 1'b0;
         mem_rvalid <= 1'b0;
         imem_rdata <= 32'h0;
      end else begin
         mem_rvalid <= 1'b0;
         if (pend_v) begin
            if (pend_cnt == 1) begin
               mem_rvalid <= 1'b1;
               imem_rdata <= word_at(pend_addr);
               pend_v     <= 1'b0;
            end else begin
               pend_cnt <= pend_cnt - 1;
            end
         end
         if (imem_req && imem_ready) begin
            if (lat == 1) begin
               mem_rvalid <= 1'b1;
               imem_rdata <= word_at(imem_addr);
            end else begin
               pend_v    <= 1'b1;
               pend_addr <= imem_addr;
               pend_cnt  <= lat - 1;
            end
         end
      end
   end

   // Scoreboard monitor: every instruction decode takes must be the next expected one.
   always @(negedge clk) begin
      if (!reset && validD && !stallD && !redirect) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got pc=%h instr=%h, required nothing", pcD, instrD);
         end else begin
            e = exp_q.pop_front();
            if ({pcD, instrD} !== e) begin
               errors++;
               $display("FAIL scoreboard: got pc=%h instr=%h, required pc=%h instr=%h",
                        pcD, instrD, e[63:32], e[31:0]);
            end
         end
      end
   end

   // Second instance: reset PC at the top of the address space must wrap to zero.
   logic        w_req, w_valid, w_rvalid;
   logic [31:0] w_addr, w_instr, w_pc;
   logic [31:0] w_addrs[$];
   always @(posedge clk) begin
      if (reset) begin
         w_rvalid <= 1'b0;
      end else begin
         w_rvalid <= w_req;
         if (w_req && w_addrs.size() < 2) w_addrs.push_back(w_addr);
      end
   end

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (w_req),
      .imem_addr  (w_addr),
      .imem_ready (1'b1),
      .imem_rvalid(w_rvalid),
      .imem_rdata (32'h0000_0013),
      .redirect   (1'b0),
      .redirect_pc(32'h0),
      .stallD     (1'b0),
      .validD     (w_valid),
      .instrD     (w_instr),
      .pcD        (w_pc)
   );

   task tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!validD && n < 20) begin
         tick();
         n++;
      end
      if (!validD) begin
         checks++;
         errors++;
         $display("FAIL %s: validD got 0 after 20 cycles, required 1", name);
      end
   endtask

   task automatic push(input logic [31:0] pc);
      exp_q.push_back({pc, word_at(pc)});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation got stuck, required completion");
      $fatal(1);
   end

   initial begin
      // Reset values and request gating
      repeat (3) tick();
      chk("reset_req", {31'b0, imem_req}, 32'd0);
      chk("reset_valid", {31'b0, validD}, 32'd0);
      chk("reset_instr", instrD, 32'h0000_0013);
      chk("reset_pc", pcD, 32'h0);

      // Basic fetch, 1-cycle memory
      push(32'h1000);
      push(32'h1004);
      reset = 1'b0;
      #1;
      chk("first_req", {31'b0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h1000);
      tick();
      chk("wait_no_req", {31'b0, imem_req}, 32'd0);
      tick();
      chk("first_valid", {31'b0, validD}, 32'd1);
      chk("first_pcD", pcD, 32'h1000);
      chk("first_instrD", instrD, 32'h00A0_0093);
      chk("second_addr", imem_addr, 32'h1004);
      tick();
      imem_ready = 1'b0;
      chk("consumed_valid", {31'b0, validD}, 32'd0);
      tick();
      chk("second_valid", {31'b0, validD}, 32'd1);
      chk("second_pcD", pcD, 32'h1004);
      tick();
      tick();

      // Decode stall fills the skid buffer
      push(32'h1008);
      push(32'h100C);
      stallD = 1'b1;
      imem_ready = 1'b1;
      repeat (4) tick();
      imem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("skid_blocks_req", {31'b0, imem_req}, 32'd0);
         chk("stall_hold_pcD", pcD, 32'h1008);
         tick();
      end
      stallD = 1'b0;
      tick();
      chk("skid_drain_valid", {31'b0, validD}, 32'd1);
      chk("skid_drain_pcD", pcD, 32'h100C);
      chk("after_skid_addr", imem_addr, 32'h1010);
      tick();

      // Redirect while waiting on a 3-cycle memory
      lat = 3;
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h2002;
      push(32'h2000);
      tick();
      redirect = 1'b0;
      for (int n = 0; n < 10 && !imem_req; n++) begin
         chk("drop_no_valid", {31'b0, validD}, 32'd0);
         tick();
      end
      chk("redirect_req", {31'b0, imem_req}, 32'd1);
      chk("redirect_addr", imem_addr, 32'h2000);
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      wait_valid("redirect_fetch");
      chk("redirect_pcD", pcD, 32'h2000);
      tick();

      // Redirect, stall and a stray rvalid together with output and skid both full
      lat = 1;
      stallD = 1'b1;
      imem_ready = 1'b1;
      repeat (4) tick();
      imem_ready = 1'b0;
      chk("full_valid", {31'b0, validD}, 32'd1);
      chk("full_pcD", pcD, 32'h2004);
      chk("full_no_req", {31'b0, imem_req}, 32'd0);
      redirect = 1'b1;
      redirect_pc = 32'h3000;
      stray_rv = 1'b1;
      tick();
      redirect = 1'b0;
      stray_rv = 1'b0;
      chk("flush_valid", {31'b0, validD}, 32'd0);
      chk("flush_skid_req", {31'b0, imem_req}, 32'd1);
      chk("flush_addr", imem_addr, 32'h3000);
      stallD = 1'b0;
      push(32'h3000);
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      wait_valid("flush_fetch");
      chk("flush_pcD", pcD, 32'h3000);
      tick();

      // Reset while a fetch is outstanding
      lat = 3;
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      reset = 1'b1;
      tick();
      chk("midreset_req", {31'b0, imem_req}, 32'd0);
      tick();
      chk("midreset_valid", {31'b0, validD}, 32'd0);
      chk("midreset_instr", instrD, 32'h0000_0013);
      chk("midreset_pc", pcD, 32'h0);
      reset = 1'b0;
      #1;
      chk("restart_req", {31'b0, imem_req}, 32'd1);
      chk("restart_addr", imem_addr, 32'h1000);
      lat = 1;
      push(32'h1000);
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      wait_valid("restart_fetch");
      chk("restart_pcD", pcD, 32'h1000);
      tick();
      tick();

      // PC wrap instance and final scoreboard state
      chk("wrap_count", w_addrs.size(), 32'd2);
      if (w_addrs.size() >= 2) begin
         chk("wrap_first_addr", w_addrs[0], 32'hFFFF_FFFC);
         chk("wrap_second_addr", w_addrs[1], 32'h0000_0000);
      end
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the multicycle RISC-V processor. It holds the PC, issues word fetches to instruction memory over a request/response handshake, and presents each fetched instruction with its PC to the decode stage. Decode then derives immediates and control from it. The block includes a one-entry skid buffer so a decode stall never loses a returning word, and it handles PC redirects from branch/jump resolution, including discarding an in-flight fetch.

## Interface
- RESET_PC, 32'h0000_1000, PC of the first fetch after reset (word-aligned)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch word address; bits [1:0] always 0
- imem_ready  in  1  memory accepts request this cycle (handshake = imem_req & imem_ready)
- imem_rvalid  in  1  read data valid; at least 1 cycle after acceptance; one per accepted request
- imem_rdata  in  32  instruction word
- redirect  in  1  take new PC (branch/jump resolved)
- redirect_pc  in  32  target PC; bits [1:0] ignored, treated as 00
- stallD  in  1  decode cannot accept this cycle
- validD  out  1  instrD/pcD hold a valid instruction
- instrD  out  32  instruction to decode
- pcD  out  32  PC of instrD

## Operation
- State registers:
  - fetch_pc
  - FSM state
  - output register (validD, instrD, pcD)
  - skid buffer (skid_v, skid_instr, skid_pc)
  - req_pc: PC of the outstanding request
- At most one request is outstanding.
- FSM states:
  - REQ:
    - imem_req = ~skid_v; imem_addr = fetch_pc.
    - On acceptance: req_pc <= fetch_pc; fetch_pc <= fetch_pc + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); go to WAIT.
    - While skid_v = 1, no request is issued.
  - WAIT:
    - imem_req = 0.
    - On imem_rvalid: the word with req_pc goes to the output register if it is free or being consumed (~validD | ~stallD). Otherwise it goes to the skid buffer. Then go to REQ.
  - DROP:
    - imem_req = 0.
    - On imem_rvalid: discard the data and go to REQ.
- Consume: decode takes the output register when validD & ~stallD.
  - If the skid buffer is full, the skid entry moves to the output register in that same edge and skid_v <= 0.
  - Otherwise validD <= 0, unless a new response loads in that edge.
- Ordering: the skid entry always precedes a newer response. Because skid_v blocks requests, both can never arrive in the same edge.
- Redirect (highest priority; overrides stallD and any response in the same cycle):
  - validD <= 0; skid_v <= 0; fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - State after redirect:
    - From WAIT without rvalid this cycle: go to DROP.
    - From REQ with acceptance this cycle: go to DROP.
    - From DROP without rvalid this cycle: stay in DROP.
    - Otherwise (including WAIT with rvalid, whose data is discarded): go to REQ.
  - An unaccepted request may change address in the cycle after a redirect. Memory must not latch unaccepted requests.
- Reset:
  - fetch_pc <= RESET_PC; state <= REQ; validD <= 0; skid_v <= 0; instrD <= 32'h0000_0013 (NOP); pcD <= 0.
  - Reset mid-operation abandons any outstanding request. Memory is reset by the same signal and produces no stale rvalid.

## Timing
- During reset: imem_req = 0 (combinationally gated by reset).
- First request is in the first cycle after reset deasserts, with addr = RESET_PC.
- Latency: rvalid at edge N makes validD = 1 in cycle N+1. The next request is issued in cycle N+1.
- Throughput with 1-cycle memory, ready always 1, no stalls: one instruction every 2 cycles.
- Output hold: instrD/pcD/validD are stable while validD & stallD, except on redirect.
- Redirect at edge N: validD = 0 in cycle N+1. A request to the target issues in cycle N+1 if no fetch is outstanding. Otherwise it issues in the cycle after the discarded rvalid.
- Protocol:
  - imem_addr is stable while imem_req = 1 and imem_ready = 0, unless a redirect occurred.
  - imem_rvalid outside WAIT/DROP is a protocol error and is ignored.

## Test plan
- Reset release, RESET_PC = 32'h1000, ready = 1, 1-cycle memory returning 32'h00A00093, 32'h00108113 -> imem_addr 0x1000 then 0x1004. validD pulses with pcD = 0x1000/instrD = 0x00A00093, then pcD = 0x1004.
- Decode stall: stallD = 1 for 6 cycles after the first instruction -> the second word lands in the skid buffer. imem_req stays 0 while the skid is full. On release, pcD 0x1000 is consumed, then 0x1004 appears next cycle. No word is lost or duplicated.
- Redirect while WAIT with 3-cycle latency: redirect_pc = 32'h2002 one cycle after acceptance -> the old response is discarded. Next imem_addr = 0x2000, and validD stays 0 until the 0x2000 word returns.
- Redirect, stallD and rvalid in the same cycle, with validD = 1 and skid full -> next cycle validD = 0, skid empty, fetch_pc = target.
- PC wrap: RESET_PC = 32'hFFFF_FFFC -> second fetch address 32'h0000_0000.
- Reset asserted in WAIT, released after 2 cycles -> outputs return to reset values and the fetch restarts at RESET_PC.
